// File: rtl/psola_frame_scheduler.sv
// Frame-level start/done sequencer for the autotune PSOLA pitch-shift path.
// Optional per-state watchdog is compiled in when PSOLA_SCHED_TIMEOUT_EN is defined.
module psola_frame_scheduler #(
    parameter int WINDOW_SIZE    = 2048,
    parameter int HOP            = 1024,
    parameter int MIN_PERIOD     = 32,
    parameter int MAX_PERIOD     = 1023,
    parameter int DEFAULT_PERIOD = 256,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        sample_valid_in,
    output logic        freeze_out,
    output logic        detect_start_out,
    input  logic        detect_done_in,
    input  logic [11:0] detect_period_in,
    output logic        psola_start_out,
    output logic [11:0] psola_period_out,
    input  logic        psola_done_in,
    input  logic [11:0] psola_len_in,
    output logic        out_start_out,
    output logic [11:0] out_len_out,
    input  logic        out_busy_in,
    output logic [15:0] frame_count_out,
    output logic [15:0] drop_count_out,
    output logic        fallback_out,
    output logic        err_out
);
    localparam int CNT_W = $clog2(WINDOW_SIZE + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DETECT  = 2'd1;
    localparam logic [1:0] ST_PSOLA   = 2'd2;
    localparam logic [1:0] ST_HANDOFF = 2'd3;

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic [CNT_W-1:0] hop_cnt_r;
    logic             filled_r;
    logic [CNT_W-1:0] hop_limit_s;
    logic             hop_s;
    logic             period_ok_s;
    logic [11:0]      last_good_r;
    logic [11:0]      len_r;
    logic             exit_s;
    logic             timeout_s;

    generate
        if (HOP < 1 || HOP > WINDOW_SIZE || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("psola_frame_scheduler: HOP or TIMEOUT_CYCLES out of range");
        end
    endgenerate

    // Hop detection: full window before the first launch, then every HOP samples.
    always_comb begin
        if (filled_r) begin
            hop_limit_s = CNT_W'(HOP - 1);
        end else begin
            hop_limit_s = CNT_W'(WINDOW_SIZE - 1);
        end
        if (sample_valid_in && (hop_cnt_r == hop_limit_s)) begin
            hop_s = 1'b1;
        end else begin
            hop_s = 1'b0;
        end
    end

    assign period_ok_s = (detect_period_in >= 12'(MIN_PERIOD)) &&
                         (detect_period_in <= 12'(MAX_PERIOD));

    // Sample counter, wrapping at each hop event.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            hop_cnt_r <= '0;
            filled_r  <= 1'b0;
        end else if (hop_s) begin
            hop_cnt_r <= '0;
            filled_r  <= 1'b1;
        end else if (sample_valid_in) begin
            hop_cnt_r <= hop_cnt_r + CNT_W'(1);
        end
    end

    // Event that legitimately leaves the current wait state.
    always_comb begin
        case (state_r)
            ST_DETECT:  exit_s = detect_done_in;
            ST_PSOLA:   exit_s = psola_done_in;
            ST_HANDOFF: exit_s = !out_busy_in;
            default:    exit_s = 1'b0;
        endcase
    end

`ifdef PSOLA_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_r;

    // A real exit event in the expiring cycle wins over the watchdog.
    assign timeout_s = (state_r != ST_IDLE) && !exit_s &&
                       (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));

    // Cycles spent in the current wait state, restarted on every state change.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wd_cnt_r <= '0;
        end else if (state_next_s != state_r) begin
            wd_cnt_r <= '0;
        end else if (state_r != ST_IDLE) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_r <= '0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        case (state_r)
            ST_IDLE: begin
                if (hop_s) state_next_s = ST_DETECT;
                else       state_next_s = ST_IDLE;
            end
            ST_DETECT: begin
                if (detect_done_in) state_next_s = ST_PSOLA;
                else if (timeout_s) state_next_s = ST_IDLE;
                else                state_next_s = ST_DETECT;
            end
            ST_PSOLA: begin
                if (psola_done_in)  state_next_s = ST_HANDOFF;
                else if (timeout_s) state_next_s = ST_IDLE;
                else                state_next_s = ST_PSOLA;
            end
            ST_HANDOFF: begin
                if (exit_s || timeout_s) state_next_s = ST_IDLE;
                else                     state_next_s = ST_HANDOFF;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and all registered outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r          <= ST_IDLE;
            last_good_r      <= 12'(DEFAULT_PERIOD);
            len_r            <= 12'd0;
            freeze_out       <= 1'b0;
            detect_start_out <= 1'b0;
            psola_start_out  <= 1'b0;
            psola_period_out <= 12'(DEFAULT_PERIOD);
            out_start_out    <= 1'b0;
            out_len_out      <= 12'd0;
            frame_count_out  <= 16'd0;
            drop_count_out   <= 16'd0;
            fallback_out     <= 1'b0;
            err_out          <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            detect_start_out <= 1'b0;
            psola_start_out  <= 1'b0;
            out_start_out    <= 1'b0;
            if (timeout_s) begin
                err_out    <= 1'b1;
                freeze_out <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (hop_s) begin
                        freeze_out       <= 1'b1;
                        detect_start_out <= 1'b1;
                    end
                end
                ST_DETECT: begin
                    if (detect_done_in) begin
                        psola_start_out <= 1'b1;
                        if (period_ok_s) begin
                            last_good_r      <= detect_period_in;
                            psola_period_out <= detect_period_in;
                            fallback_out     <= 1'b0;
                        end else begin
                            psola_period_out <= last_good_r;
                            fallback_out     <= 1'b1;
                        end
                    end
                end
                ST_PSOLA: begin
                    if (psola_done_in) begin
                        len_r      <= psola_len_in;
                        freeze_out <= 1'b0;
                    end
                end
                ST_HANDOFF: begin
                    if (!out_busy_in) begin
                        out_start_out <= 1'b1;
                        out_len_out   <= len_r;
                        if (frame_count_out != 16'hFFFF) begin
                            frame_count_out <= frame_count_out + 16'd1;
                        end
                    end
                end
                default: begin
                    freeze_out <= 1'b0;
                end
            endcase
            // Hops arriving while a frame is in flight are counted, never queued.
            if (hop_s && (state_r != ST_IDLE) && (drop_count_out != 16'hFFFF)) begin
                drop_count_out <= drop_count_out + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_psola_frame_scheduler.sv
// Randomized scoreboard bench for psola_frame_scheduler; a frame-timeline model
// predicts every pulse, and a monitor compares the DUT against it each cycle.
module tb_psola_frame_scheduler;
    localparam int W    = 64;
    localparam int HOP  = 32;
    localparam int MINP = 32;
    localparam int MAXP = 1023;
    localparam int DEFP = 256;
    localparam int TMO  = 100;
    localparam int FAR  = 1 << 30;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        sample_valid_in;
    logic        freeze_out;
    logic        detect_start_out;
    logic        detect_done_in;
    logic [11:0] detect_period_in;
    logic        psola_start_out;
    logic [11:0] psola_period_out;
    logic        psola_done_in;
    logic [11:0] psola_len_in;
    logic        out_start_out;
    logic [11:0] out_len_out;
    logic        out_busy_in;
    logic [15:0] frame_count_out;
    logic [15:0] drop_count_out;
    logic        fallback_out;
    logic        err_out;

    always #5 clk_in = ~clk_in;

    psola_frame_scheduler #(
        .WINDOW_SIZE(W), .HOP(HOP), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP),
        .DEFAULT_PERIOD(DEFP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .sample_valid_in(sample_valid_in),
        .freeze_out(freeze_out), .detect_start_out(detect_start_out),
        .detect_done_in(detect_done_in), .detect_period_in(detect_period_in),
        .psola_start_out(psola_start_out), .psola_period_out(psola_period_out),
        .psola_done_in(psola_done_in), .psola_len_in(psola_len_in),
        .out_start_out(out_start_out), .out_len_out(out_len_out),
        .out_busy_in(out_busy_in), .frame_count_out(frame_count_out),
        .drop_count_out(drop_count_out), .fallback_out(fallback_out),
        .err_out(err_out)
    );

    typedef struct {int cyc; int a; int b;} exp_t;
    exp_t det_q[$];
    exp_t ps_q[$];
    exp_t out_q[$];
    exp_t me;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // Reference model: sample count, current frame timeline and running totals.
    int n_samp, n_fr, fcount, last_good, exp_drop, drop_pend, err_from;
    int f_h, f_m, f_p, f_b, f_end, f_per, f_len;
    int bnd[4] = '{31, 32, 1023, 1024};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        n_samp = 0; fcount = 0; last_good = DEFP; exp_drop = 0; drop_pend = 0;
        err_from = FAR; f_h = -100; f_m = -100; f_p = -100; f_b = 0; f_end = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " freeze"}, freeze_out, 1'b0);
        chk({tag, " detect_start"}, detect_start_out, 1'b0);
        chk({tag, " psola_start"}, psola_start_out, 1'b0);
        chk({tag, " out_start"}, out_start_out, 1'b0);
        chk({tag, " psola_period"}, psola_period_out, 12'd256);
        chk({tag, " out_len"}, out_len_out, 12'd0);
        chk({tag, " frame_count"}, frame_count_out, 16'd0);
        chk({tag, " drop_count"}, drop_count_out, 16'd0);
        chk({tag, " fallback"}, fallback_out, 1'b0);
        chk({tag, " err"}, err_out, 1'b0);
    endtask

    // One clock of stimulus; a launch plans the entire frame timeline up front.
    task automatic run_cycle(input int dens, input bit abort, output bit launched);
        int r1, r2, per, fb;
        bit hop, dd, pd;
        @(posedge clk_in);
        cyc++;
        #1;
        rst_in = 1'b1;
        exp_drop += drop_pend;
        drop_pend = 0;
        launched = 1'b0;
        sample_valid_in = ($urandom_range(0, 99) < dens);
        hop = 1'b0;
        if (sample_valid_in) begin
            n_samp++;
            hop = (n_samp == W) || (n_samp > W && ((n_samp - W) % HOP) == 0);
        end
        if (hop && cyc >= f_end) begin
            launched = 1'b1;
            f_h = cyc;
            det_q.push_back('{cyc + 1, 0, 0});
            if (abort) begin
                f_m = FAR; f_p = FAR; f_b = 0; f_end = FAR;
            end else begin
                r1 = (n_fr < 4) ? $urandom_range(0, 3) : $urandom_range(0, 8);
                if (n_fr == 3) r2 = 80;
                else if (n_fr < 3) r2 = $urandom_range(0, 3);
                else if ($urandom_range(0, 3) == 0) r2 = $urandom_range(30, 80);
                else r2 = $urandom_range(0, 6);
                f_b = (n_fr == 1) ? 10 : (n_fr == 0) ? 0 : $urandom_range(0, 10);
                f_m = cyc + 1 + r1;
                f_p = f_m + 1 + r2;
                f_end = f_p + 2 + f_b;
                case ($urandom_range(0, 5))
                    0:       per = $urandom_range(0, 31);
                    1:       per = $urandom_range(1024, 4095);
                    2:       per = bnd[$urandom_range(0, 3)];
                    default: per = $urandom_range(32, 1023);
                endcase
                if (n_fr == 0 || n_fr == 2) per = 5;
                if (n_fr == 1) per = 100;
                f_per = per;
                f_len = (n_fr == 1) ? 90 : $urandom_range(0, 4095);
                if (per >= MINP && per <= MAXP) begin
                    last_good = per;
                    fb = 0;
                end else begin
                    fb = 1;
                end
                ps_q.push_back('{f_m + 1, last_good, fb});
                fcount++;
                out_q.push_back('{f_end, f_len, fcount});
                n_fr++;
            end
        end else if (hop) begin
            drop_pend = 1;
        end
        dd = (cyc == f_m);
        pd = (cyc == f_p);
        // Stray done pulses only where the scheduler must ignore them.
        if (!dd && !(cyc > f_h && cyc <= f_m) && $urandom_range(0, 7) == 0) dd = 1'b1;
        if (!pd && !(cyc > f_m && cyc <= f_p) && $urandom_range(0, 7) == 0) pd = 1'b1;
        detect_done_in   = dd;
        psola_done_in    = pd;
        detect_period_in = (cyc == f_m) ? 12'(f_per) : 12'($urandom_range(0, 4095));
        psola_len_in     = (cyc == f_p) ? 12'(f_len) : 12'($urandom_range(0, 4095));
        if (cyc > f_p && cyc <= f_p + 1 + f_b) out_busy_in = (cyc <= f_p + f_b);
        else out_busy_in = 1'($urandom_range(0, 1));
    endtask

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk_in) begin
        if (mon_en) begin
            chk("detect_start", detect_start_out, (det_q.size() > 0 && det_q[0].cyc == cyc));
            if (det_q.size() > 0 && det_q[0].cyc == cyc) void'(det_q.pop_front());
            if (ps_q.size() > 0 && ps_q[0].cyc == cyc) begin
                me = ps_q.pop_front();
                chk("psola_start", psola_start_out, 1'b1);
                chk("psola_period", psola_period_out, me.a);
                chk("fallback", fallback_out, me.b);
            end else begin
                chk("psola_start", psola_start_out, 1'b0);
            end
            if (out_q.size() > 0 && out_q[0].cyc == cyc) begin
                me = out_q.pop_front();
                chk("out_start", out_start_out, 1'b1);
                chk("out_len", out_len_out, me.a);
                chk("frame_count", frame_count_out, me.b);
            end else begin
                chk("out_start", out_start_out, 1'b0);
            end
            chk("freeze", freeze_out, (cyc > f_h && cyc <= f_p));
            chk("drop_count", drop_count_out, exp_drop);
            chk("err", err_out, (cyc >= err_from));
        end
    end

    initial begin
        bit l;
        int dens;
        int dtab[4] = '{20, 50, 90, 100};
        n_fr = 0;
        model_reset();
        rst_in = 1'b0; sample_valid_in = 1'b0; detect_done_in = 1'b0; psola_done_in = 1'b0;
        detect_period_in = 12'd0; psola_len_in = 12'd0; out_busy_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check_reset_values("power-on");
        mon_en = 1'b1;
        dens = 100;
        for (int i = 0; i < 2500; i++) begin
            if (cyc >= 400 && (cyc % 100) == 0) dens = dtab[$urandom_range(0, 3)];
            run_cycle(dens, 1'b0, l);
        end

        // Reset in the first DETECT cycle of a fresh frame.
        l = 1'b0;
        for (int i = 0; i < 600 && !l; i++) run_cycle(60, 1'b1, l);
        chk("launch before reset", l, 1'b1);
        @(posedge clk_in);
        cyc++;
        #1;
        rst_in = 1'b0; sample_valid_in = 1'b0; detect_done_in = 1'b0; psola_done_in = 1'b0;
        @(posedge clk_in);
        cyc++;
        #1;
        rst_in = 1'b1;
        model_reset();
        check_reset_values("mid-detect reset");

`ifdef PSOLA_SCHED_TIMEOUT_EN
        l = 1'b0;
        for (int i = 0; i < 300 && !l; i++) run_cycle(100, 1'b1, l);
        chk("launch before timeout", l, 1'b1);
        f_p = f_h + TMO;
        f_end = f_h + TMO + 1;
        err_from = f_h + TMO + 1;
        for (int i = 0; i < TMO + 5; i++) run_cycle(0, 1'b1, l);
        chk("timeout err", err_out, 1'b1);
        chk("timeout freeze", freeze_out, 1'b0);
`endif

        for (int i = 0; i < 5; i++) run_cycle(0, 1'b1, l);
        mon_en = 1'b0;
        chk("detect queue drained", det_q.size(), 32'd0);
        chk("psola queue drained", ps_q.size(), 32'd0);
        chk("out queue drained", out_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
